// File: rtl/jtag_debug_pkg.sv
// Shared defaults and the queue entry layout for the JTAG debug command path.
package jtag_debug_pkg;
    localparam int DR_W       = 38;
    localparam int IR_W       = 2;
    localparam int ACTION_BIT = 34;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] jdo;
    } entry_t;
endpackage

// File: rtl/jtag_debug_cmd_queue_if.sv
// Command stream from the queue to its consumer: valid/ready with the head entry.
interface jtag_debug_cmd_queue_if #(
    parameter int IR_W = jtag_debug_pkg::IR_W,
    parameter int DR_W = jtag_debug_pkg::DR_W
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_jdo;
    logic            cmd_action;

    modport master (
        output cmd_valid, cmd_ir, cmd_jdo, cmd_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_jdo, cmd_action,
        output cmd_ready
    );
endinterface

// File: rtl/jtag_debug_strobe_sync.sv
// Brings a tck-domain strobe level into clk and emits a registered one-cycle pulse
// on each rising edge.
module jtag_debug_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic pulse
);
    localparam int ARM_CNT = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_CNT + 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   edge_reg;
    logic                   pulse_reg;
    logic [ARM_W-1:0]       arm_reg;
    logic                   armed;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= strobe;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    // Edges are ignored until the chain has refilled after reset, so a strobe
    // already high at release is absorbed into edge_reg instead of pulsing.
    assign armed = (arm_reg == ARM_W'(ARM_CNT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_reg  <= 1'b0;
            pulse_reg <= 1'b0;
            arm_reg   <= '0;
        end else begin
            edge_reg  <= sync_reg[SYNC_STAGES-1];
            pulse_reg <= armed & sync_reg[SYNC_STAGES-1] & ~edge_reg;
            if (!armed) begin
                arm_reg <= arm_reg + ARM_W'(1);
            end
        end
    end

    assign pulse = pulse_reg;
endmodule

// File: rtl/jtag_debug_cmd_queue.sv
// Captures {ir, dr} on each update-DR strobe into a small FIFO for the clk-domain
// debug logic, with sticky overflow and an update-IR pulse.
module jtag_debug_cmd_queue #(
    parameter int DR_W        = jtag_debug_pkg::DR_W,
    parameter int IR_W        = jtag_debug_pkg::IR_W,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACTION_BIT  = jtag_debug_pkg::ACTION_BIT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         vs_udr,
    input  logic                         vs_uir,
    input  logic [IR_W-1:0]              ir_in,
    input  logic [DR_W-1:0]              sr,
    input  logic                         flush,
    input  logic                         overflow_clr,
    output logic                         ir_update,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    jtag_debug_cmd_queue_if.master       cmd
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] jdo;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             overflow_reg;

    logic udr_pulse;
    logic uir_pulse;
    logic valid;
    logic full;
    logic push_ok;
    logic pop_ok;
    logic drop;

    jtag_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (vs_udr),
        .pulse   (udr_pulse)
    );

    jtag_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (vs_uir),
        .pulse   (uir_pulse)
    );

    // A pop frees the slot the same cycle, so a push at full still lands.
    always_comb begin
        valid   = (level_reg != '0);
        full    = (level_reg == LVL_W'(DEPTH));
        pop_ok  = valid & cmd.cmd_ready & ~flush;
        push_ok = udr_pulse & (~full | pop_ok) & ~flush;
        drop    = udr_pulse & full & ~pop_ok & ~flush;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= '{ir: ir_in, jdo: sr};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push_ok && !pop_ok) begin
                level_reg <= level_reg + LVL_W'(1);
            end else if (pop_ok && !push_ok) begin
                level_reg <= level_reg - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (overflow_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    assign head           = mem[rd_ptr_reg];
    assign cmd.cmd_valid  = valid;
    assign cmd.cmd_ir     = head.ir;
    assign cmd.cmd_jdo    = head.jdo;
    assign cmd.cmd_action = head.jdo[ACTION_BIT];
    assign ir_update      = uir_pulse;
    assign level          = level_reg;
    assign overflow       = overflow_reg;
endmodule
